range_decode_sequencer: RTL and testbench
=========================================

// Module: range_decode_sequencer
// PURPOSE
//  Sequences the LiDAR entropy decoder's range calculator over one frame of symbols.
//  Accepts symbols over valid/ready and drives init_pulse / update_en / normalize_en.
//  Captures decoded_range and error_flag, returns results over valid/ready and reports frame status.
//  Sits between the symbol parser and the range calculator.
// PARAMETERS
//  LEN_W      16  width of frame length and symbol counters
//  SETTLE     1   idle cycles after symbol load before update_en (prob lookup latency), 1..3
//  ABORT_ERR  1   1: stop decoding on first rc error and flush the rest of the frame; 0: continue
//  ERRCNT_W   8   width of saturating per-frame error counter
// PORTS
//  clk              in   1      clock
//  reset            in   1      synchronous, active-high reset
//  frame_start      in   1      1-cycle pulse, begin frame (ignored unless IDLE)
//  frame_len        in   LEN_W  symbols in frame, sampled on accepted frame_start
//  sym_valid        in   1      symbol available
//  sym_ready        out  1      symbol accepted when sym_valid&sym_ready
//  sym_data         in   8      encoded symbol
//  sym_bits         in   16     bitstream word paired with symbol
//  rc_init_pulse    out  1      to calculator init_pulse
//  rc_update_en     out  1      to calculator update_en
//  rc_normalize_en  out  1      to calculator normalize_en
//  rc_encoded_data  out  8      held symbol to calculator
//  rc_bitstream     out  16     held bitstream to calculator
//  rc_decoded_range in   16     calculator result
//  rc_error_flag    in   1      calculator error
//  out_valid        out  1      result available
//  out_ready        in   1      downstream accepts
//  out_range        out  16     decoded range
//  out_err          out  1      result carried rc error
//  out_last         out  1      final result of frame
//  busy             out  1      high in every state except IDLE
//  frame_done       out  1      1-cycle pulse at frame end
//  frame_error      out  1      valid with frame_done: any error in frame
//  err_count        out  ERRCNT_W  errors this frame, saturating, held until next frame_start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; held symbol/bitstream 0.
//  States: IDLE->INIT->LOAD->SETTLE->UPDATE->NORM->CAPT->OUT->(LOAD|DONE); FLUSH; DONE->IDLE.
//  IDLE: frame_start latches frame_len, clears err_count, remaining := frame_len; go INIT.
//  INIT: rc_init_pulse=1 for exactly 1 cycle; remaining==0 -> DONE, else LOAD.
//  LOAD: sym_ready=1; on handshake latch sym_data/sym_bits to rc_* regs, go SETTLE. sym_ready=0 in all other states except FLUSH.
//  SETTLE: wait SETTLE cycles; UPDATE: rc_update_en=1 one cycle; NORM: rc_normalize_en=1 one cycle.
//  CAPT: one cycle after NORM; register rc_decoded_range/rc_error_flag into out_range/out_err; decrement remaining.
//  rc_encoded_data/rc_bitstream stable from LOAD handshake through CAPT.
//  OUT: out_valid=1, payload stable until out_ready; out_last=1 when remaining==0 or aborting.
//   On handshake: remaining==0 -> DONE; out_err&ABORT_ERR&remaining!=0 -> FLUSH; else LOAD.
//  Per symbol: 1+SETTLE+3 cycles LOAD-handshake to out_valid; max throughput 1 symbol / (SETTLE+5) cycles.
//  FLUSH: sym_ready=1, discard symbols, decrement remaining per handshake; remaining==0 -> DONE.
//  DONE: frame_done=1 one cycle, frame_error=(err_count!=0); -> IDLE.
//  err_count increments in CAPT when rc_error_flag=1, saturates at all-ones.
//  frame_start outside IDLE ignored; simultaneous frame_start with DONE is ignored.
//  Reset mid-frame: immediate return to IDLE, no frame_done; rc enables deasserted same edge.
//  At most one of rc_init_pulse/rc_update_en/rc_normalize_en high in any cycle.
// STRUCTURE
//  Package range_dec_pkg: state enum, SYM_W=8, BITS_W=16, RANGE_W=16 constants.
//  Single module; FSM, remaining/settle counters and error counter inline; no sub-module.
// TESTING
//  frame_len=3, no errors, out_ready=1 -> 3 results, out_last on 3rd, frame_done, frame_error=0, err_count=0.
//  frame_len=0 -> rc_init_pulse once, no sym_ready, frame_done 2 cycles after start, no out_valid.
//  frame_len=4, rc_error_flag on symbol 2, ABORT_ERR=1 -> 2 results (2nd out_err=1, out_last=1), 2 symbols flushed, frame_error=1.
//  Same with ABORT_ERR=0 -> 4 results, only 2nd out_err=1, err_count=1.
//  out_ready low 5 cycles on result 1 -> out_range stable, no sym_ready, no rc enables until release.
//  Reset asserted in NORM -> next cycle busy=0, all rc_* enables 0, no frame_done; new frame decodes normally.

Source files
------------

// File: rtl/range_dec_pkg.sv
// Shared types and datapath widths for the range decoder sequencer.
package range_dec_pkg;

  localparam int SYM_W   = 8;
  localparam int BITS_W  = 16;
  localparam int RANGE_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_SETTLE,
    ST_UPDATE,
    ST_NORM,
    ST_CAPT,
    ST_OUT,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/range_decode_sequencer.sv
// Steps the entropy decoder's range calculator through one frame of symbols,
// one symbol at a time, and hands each decoded range downstream.
//
// state  | meaning
// IDLE   | waiting for frame_start
// INIT   | rc_init_pulse high, frame length already latched
// LOAD   | sym_ready high, waiting for the next symbol
// SETTLE | probability lookup latency after a symbol load
// UPDATE | rc_update_en high
// NORM   | rc_normalize_en high
// CAPT   | capture calculator result, count errors
// OUT    | result presented, waiting for out_ready
// FLUSH  | discarding the rest of an aborted frame
// DONE   | frame_done pulse
module range_decode_sequencer
  import range_dec_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int SETTLE    = 1,
  parameter bit ABORT_ERR = 1'b1,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic [SYM_W-1:0]    sym_data,
  input  logic [BITS_W-1:0]   sym_bits,
  output logic                rc_init_pulse,
  output logic                rc_update_en,
  output logic                rc_normalize_en,
  output logic [SYM_W-1:0]    rc_encoded_data,
  output logic [BITS_W-1:0]   rc_bitstream,
  input  logic [RANGE_W-1:0]  rc_decoded_range,
  input  logic                rc_error_flag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RANGE_W-1:0]  out_range,
  output logic                out_err,
  output logic                out_last,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_error,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [1:0]          SETTLE_LOAD = 2'(SETTLE - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX     = '1;
  localparam logic [LEN_W-1:0]    LEN_ONE     = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       settle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      remaining       <= '0;
      settle_cnt      <= '0;
      sym_ready       <= 1'b0;
      rc_init_pulse   <= 1'b0;
      rc_update_en    <= 1'b0;
      rc_normalize_en <= 1'b0;
      rc_encoded_data <= '0;
      rc_bitstream    <= '0;
      out_valid       <= 1'b0;
      out_range       <= '0;
      out_err         <= 1'b0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
      err_count       <= '0;
    end else begin
      // Strobes are one cycle wide; only the transition that needs one re-arms it.
      rc_init_pulse   <= 1'b0;
      rc_update_en    <= 1'b0;
      rc_normalize_en <= 1'b0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            remaining     <= frame_len;
            err_count     <= '0;
            rc_init_pulse <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_INIT;
          end
        end

        ST_INIT: begin
          if (remaining == '0) begin
            frame_done  <= 1'b1;
            frame_error <= (err_count != '0);
            state       <= ST_DONE;
          end else begin
            sym_ready <= 1'b1;
            state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (sym_valid) begin
            rc_encoded_data <= sym_data;
            rc_bitstream    <= sym_bits;
            sym_ready       <= 1'b0;
            settle_cnt      <= SETTLE_LOAD;
            state           <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == 2'd0) begin
            rc_update_en <= 1'b1;
            state        <= ST_UPDATE;
          end else begin
            settle_cnt <= settle_cnt - 2'd1;
          end
        end

        ST_UPDATE: begin
          rc_normalize_en <= 1'b1;
          state           <= ST_NORM;
        end

        ST_NORM: state <= ST_CAPT;

        ST_CAPT: begin
          out_range <= rc_decoded_range;
          out_err   <= rc_error_flag;
          out_valid <= 1'b1;
          // Last result either ends the frame or triggers the abort flush.
          out_last  <= (remaining == LEN_ONE) || (rc_error_flag && ABORT_ERR);
          remaining <= remaining - LEN_ONE;
          if (rc_error_flag && (err_count != ERR_MAX))
            err_count <= err_count + 1'b1;
          state <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (remaining == '0) begin
              frame_done  <= 1'b1;
              frame_error <= (err_count != '0);
              state       <= ST_DONE;
            end else if (out_err && ABORT_ERR) begin
              sym_ready <= 1'b1;
              state     <= ST_FLUSH;
            end else begin
              sym_ready <= 1'b1;
              state     <= ST_LOAD;
            end
          end
        end

        ST_FLUSH: begin
          if (sym_valid) begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              sym_ready   <= 1'b0;
              frame_done  <= 1'b1;
              frame_error <= (err_count != '0);
              state       <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_decode_sequencer.sv
// Scoreboard bench: instance 0 aborts on error, instance 1 keeps decoding.
// A stub calculator returns bits + symbol and flags an error on symbol 0xEE.
module tb_range_decode_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_start [2];
  logic [15:0] frame_len   [2];
  logic        sym_valid   [2];
  logic        sym_ready   [2];
  logic [7:0]  sym_data    [2];
  logic [15:0] sym_bits    [2];
  logic        rc_init     [2];
  logic        rc_upd      [2];
  logic        rc_norm     [2];
  logic [7:0]  rc_enc      [2];
  logic [15:0] rc_bits     [2];
  logic [15:0] rc_range    [2];
  logic        rc_err      [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [15:0] out_range   [2];
  logic        out_err     [2];
  logic        out_last    [2];
  logic        busy        [2];
  logic        frame_done  [2];
  logic        frame_error [2];
  logic [7:0]  err_count   [2];

  typedef struct { int tag; logic [7:0] d; logic [15:0] b; } sym_t;
  typedef struct { int tag; logic [15:0] r; logic e; logic l; } res_t;
  typedef struct { int tag; logic fe; logic [7:0] ec; } frm_t;

  sym_t sym_q[$];
  res_t res_q[$];
  frm_t frm_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_init [2];
  int n_srdy [2];
  int n_ov   [2];
  logic hs   [2];

  range_decode_sequencer #(.LEN_W(16), .SETTLE(1), .ABORT_ERR(1'b1), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start[0]), .frame_len(frame_len[0]),
    .sym_valid(sym_valid[0]), .sym_ready(sym_ready[0]), .sym_data(sym_data[0]),
    .sym_bits(sym_bits[0]), .rc_init_pulse(rc_init[0]), .rc_update_en(rc_upd[0]),
    .rc_normalize_en(rc_norm[0]), .rc_encoded_data(rc_enc[0]), .rc_bitstream(rc_bits[0]),
    .rc_decoded_range(rc_range[0]), .rc_error_flag(rc_err[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_range(out_range[0]), .out_err(out_err[0]),
    .out_last(out_last[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .frame_error(frame_error[0]), .err_count(err_count[0]));

  range_decode_sequencer #(.LEN_W(16), .SETTLE(1), .ABORT_ERR(1'b0), .ERRCNT_W(8)) dut_cont (
    .clk(clk), .reset(reset), .frame_start(frame_start[1]), .frame_len(frame_len[1]),
    .sym_valid(sym_valid[1]), .sym_ready(sym_ready[1]), .sym_data(sym_data[1]),
    .sym_bits(sym_bits[1]), .rc_init_pulse(rc_init[1]), .rc_update_en(rc_upd[1]),
    .rc_normalize_en(rc_norm[1]), .rc_encoded_data(rc_enc[1]), .rc_bitstream(rc_bits[1]),
    .rc_decoded_range(rc_range[1]), .rc_error_flag(rc_err[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_range(out_range[1]), .out_err(out_err[1]),
    .out_last(out_last[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .frame_error(frame_error[1]), .err_count(err_count[1]));

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rc_range[k] = rc_bits[k] + {8'h00, rc_enc[k]};
      rc_err[k]   = (rc_enc[k] == 8'hEE);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_sym(input int k, input logic [7:0] d, input logic [15:0] b);
    sym_t s;
    s.tag = k; s.d = d; s.b = b;
    sym_q.push_back(s);
  endtask

  task automatic push_res(input int k, input logic [15:0] r, input logic e, input logic l);
    res_t s;
    s.tag = k; s.r = r; s.e = e; s.l = l;
    res_q.push_back(s);
  endtask

  task automatic push_frm(input int k, input logic fe, input logic [7:0] ec);
    frm_t s;
    s.tag = k; s.fe = fe; s.ec = ec;
    frm_q.push_back(s);
  endtask

  // Symbol source: pops on the handshake seen at the previous falling edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      sym_valid[k] = 1'b0; sym_data[k] = '0; sym_bits[k] = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++)
        if (hs[k] && sym_q.size() != 0) void'(sym_q.pop_front());
      for (int k = 0; k < 2; k++) begin
        if (sym_q.size() != 0 && sym_q[0].tag == k) begin
          sym_valid[k] = 1'b1; sym_data[k] = sym_q[0].d; sym_bits[k] = sym_q[0].b;
        end else begin
          sym_valid[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: inputs change only after rising edges, so falling-edge values
  // are exactly what the DUT samples at the next rising edge.
  initial begin
    res_t r;
    frm_t f;
    for (int k = 0; k < 2; k++) begin
      n_init[k] = 0; n_srdy[k] = 0; n_ov[k] = 0; hs[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] && out_ready[k] && !reset) begin
          n_ov[k]++;
          if (res_q.size() == 0) begin
            chk("unexpected_result", 32'(out_range[k]), 32'hFFFF_FFFF);
          end else begin
            r = res_q.pop_front();
            chk("res_inst", 32'(k), 32'(r.tag));
            chk("out_range", 32'(out_range[k]), 32'(r.r));
            chk("out_err", 32'(out_err[k]), 32'(r.e));
            chk("out_last", 32'(out_last[k]), 32'(r.l));
          end
        end
        if (frame_done[k]) begin
          if (frm_q.size() == 0) begin
            chk("unexpected_frame_done", 32'(k), 32'hFFFF_FFFF);
          end else begin
            f = frm_q.pop_front();
            chk("frm_inst", 32'(k), 32'(f.tag));
            chk("frame_error", 32'(frame_error[k]), 32'(f.fe));
            chk("err_count", 32'(err_count[k]), 32'(f.ec));
          end
        end
        if ((32'(rc_init[k]) + 32'(rc_upd[k]) + 32'(rc_norm[k])) > 1)
          chk("rc_enable_onehot", 32'(rc_init[k]) + 32'(rc_upd[k]) + 32'(rc_norm[k]), 32'd1);
        n_init[k] += int'(rc_init[k]);
        n_srdy[k] += int'(sym_ready[k]);
        hs[k] = sym_valid[k] && sym_ready[k] && !reset;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int k, input logic [15:0] len);
    frame_start[k] = 1'b1;
    frame_len[k]   = len;
    tick();
    frame_start[k] = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy[0] && !busy[1] && res_q.size() == 0 && frm_q.size() == 0 && sym_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_init, b_srdy, b_ov;
    logic ok;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      frame_start[k] = 1'b0; frame_len[k] = '0; out_ready[k] = 1'b1;
    end
    tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(busy[k]), 0);
      chk("rst_sym_ready", 32'(sym_ready[k]), 0);
      chk("rst_out_valid", 32'(out_valid[k]), 0);
      chk("rst_rc_en", 32'(rc_init[k]) + 32'(rc_upd[k]) + 32'(rc_norm[k]), 0);
      chk("rst_err_count", 32'(err_count[k]), 0);
      chk("rst_rc_hold", {8'h00, rc_enc[k], rc_bits[k]}, 0);
      chk("rst_out_range", 32'(out_range[k]), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Clean 3-symbol frame; a stray frame_start mid-frame must be ignored.
    push_sym(0, 8'h0A, 16'h0100); push_sym(0, 8'h14, 16'h0200); push_sym(0, 8'h1E, 16'h0300);
    push_res(0, 16'h010A, 0, 0); push_res(0, 16'h0214, 0, 0); push_res(0, 16'h031E, 0, 1);
    push_frm(0, 0, 8'd0);
    start_frame(0, 16'd3);
    repeat (3) tick();
    start_frame(0, 16'd7);
    drain("drain_len3", 200);
    chk("err_count_len3", 32'(err_count[0]), 0);

    // Empty frame: init pulse only, frame_done two cycles after the start cycle.
    b_init = n_init[0]; b_srdy = n_srdy[0]; b_ov = n_ov[0];
    push_frm(0, 0, 8'd0);
    frame_start[0] = 1'b1; frame_len[0] = 16'd0;
    @(negedge clk);
    chk("len0_idle", 32'(busy[0]), 0);
    @(posedge clk); #1;
    frame_start[0] = 1'b0;
    @(negedge clk);
    chk("len0_init_pulse", 32'(rc_init[0]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_frame_done", 32'(frame_done[0]), 1);
    drain("drain_len0", 20);
    chk("len0_init_count", 32'(n_init[0] - b_init), 1);
    chk("len0_sym_ready", 32'(n_srdy[0] - b_srdy), 0);
    chk("len0_out_valid", 32'(n_ov[0] - b_ov), 0);

    // Downstream stall on the first result.
    push_sym(0, 8'h05, 16'h1000); push_sym(0, 8'h06, 16'h2000);
    push_res(0, 16'h1005, 0, 0); push_res(0, 16'h2006, 0, 1);
    push_frm(0, 0, 8'd0);
    out_ready[0] = 1'b0;
    start_frame(0, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid[0]) begin ok = 1'b1; break; end
    end
    chk("stall_wait_valid", 32'(ok), 1);
    for (int j = 0; j < 5; j++) begin
      chk("stall_out_range", 32'(out_range[0]), 32'h1005);
      chk("stall_out_valid", 32'(out_valid[0]), 1);
      chk("stall_sym_ready", 32'(sym_ready[0]), 0);
      chk("stall_rc_en", 32'(rc_init[0]) + 32'(rc_upd[0]) + 32'(rc_norm[0]), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    drain("drain_stall", 200);

    // Error on symbol 2 with abort: two results, two symbols flushed.
    push_sym(0, 8'h01, 16'h0010); push_sym(0, 8'hEE, 16'h0100);
    push_sym(0, 8'h03, 16'h0200); push_sym(0, 8'h04, 16'h0300);
    push_res(0, 16'h0011, 0, 0); push_res(0, 16'h01EE, 1, 1);
    push_frm(0, 1, 8'd1);
    start_frame(0, 16'd4);
    drain("drain_abort", 200);
    chk("abort_err_count_held", 32'(err_count[0]), 1);

    // Same frame without abort: four results, only the second flagged.
    push_sym(1, 8'h01, 16'h0010); push_sym(1, 8'hEE, 16'h0100);
    push_sym(1, 8'h03, 16'h0200); push_sym(1, 8'h04, 16'h0300);
    push_res(1, 16'h0011, 0, 0); push_res(1, 16'h01EE, 1, 0);
    push_res(1, 16'h0203, 0, 0); push_res(1, 16'h0304, 0, 1);
    push_frm(1, 1, 8'd1);
    start_frame(1, 16'd4);
    drain("drain_continue", 200);
    chk("cont_err_count_held", 32'(err_count[1]), 1);

    // Reset while in NORM, then a fresh frame.
    push_sym(0, 8'h11, 16'h1100); push_sym(0, 8'h22, 16'h2200);
    start_frame(0, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rc_upd[0]) begin ok = 1'b1; break; end
    end
    chk("rst_wait_update", 32'(ok), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    sym_q.delete();
    @(negedge clk);
    chk("rst_in_norm", 32'(rc_norm[0]), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy[0]), 0);
    chk("midrst_rc_en", 32'(rc_init[0]) + 32'(rc_upd[0]) + 32'(rc_norm[0]), 0);
    chk("midrst_out_valid", 32'(out_valid[0]), 0);
    chk("midrst_frame_done", 32'(frame_done[0]), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    push_sym(0, 8'h42, 16'h4200);
    push_res(0, 16'h4242, 0, 1);
    push_frm(0, 0, 8'd0);
    start_frame(0, 16'd1);
    drain("drain_after_reset", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
